// File: rtl/ndp_result_drain.sv
// Snapshots the NDP result vector on a calc-done rising edge (optional ReLU)
// and streams it out as LANES-wide beats over valid/ready.

module ndp_relu_elem #(
    parameter int WIDTH = 8
) (
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    assign q = (en && d[WIDTH-1]) ? '0 : d;
endmodule

module ndp_result_drain #(
    parameter int WIDTH     = 8,
    parameter int NUM_ELEMS = 1024,
    parameter int LANES     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       calc_done_flag,
    input  logic [NUM_ELEMS*WIDTH-1:0] in_c,
    input  logic                       relu_en,
    input  logic                       clear_err,
    output logic [LANES*WIDTH-1:0]     m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_last,
    output logic                       busy,
    output logic                       drain_done,
    output logic                       overrun_err
);
    localparam int BEATS = NUM_ELEMS / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                          state, state_nxt;
    logic [NUM_ELEMS-1:0][WIDTH-1:0] relu_c;
    logic [NUM_ELEMS-1:0][WIDTH-1:0] holding;
    logic [CNT_W-1:0]                beat_cnt;
    logic                            done_d;
    logic                            rise, hs, last_beat, final_hs, capture, overrun_set;

    genvar e;
    generate
        for (e = 0; e < NUM_ELEMS; e++) begin : g_relu
            ndp_relu_elem #(.WIDTH(WIDTH)) u_relu (
                .en (relu_en),
                .d  (in_c[e*WIDTH +: WIDTH]),
                .q  (relu_c[e])
            );
        end
    endgenerate

    assign rise        = calc_done_flag & ~done_d;
    assign hs          = (state == SEND) & m_ready;
    assign last_beat   = (beat_cnt == CNT_W'(BEATS - 1));
    assign final_hs    = hs & last_beat;
    // A rise landing on the final handshake is a legal back-to-back job.
    assign capture     = rise & ((state == IDLE) | final_hs);
    assign overrun_set = rise & (state == SEND) & ~final_hs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = SEND;
            SEND:    if (final_hs && !rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_valid = (state == SEND);
        busy    = (state == SEND);
        m_last  = (state == SEND) & last_beat;
        m_data  = '0;
        if (state == SEND) m_data = holding[beat_cnt*LANES +: LANES];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_d      <= 1'b0;
            holding     <= '0;
            beat_cnt    <= '0;
            drain_done  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            done_d     <= calc_done_flag;
            drain_done <= final_hs;
            if (capture) begin
                holding  <= relu_c;
                beat_cnt <= '0;
            end else if (hs) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
            end
            if (overrun_set)    overrun_err <= 1'b1;
            else if (clear_err) overrun_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ndp_result_drain.sv
// Scoreboard bench for ndp_result_drain: stimulus pushes expected beats,
// a monitor pops and compares on each handshake.

module tb_ndp_result_drain;
    localparam int WIDTH     = 8;
    localparam int NUM_ELEMS = 1024;
    localparam int LANES     = 16;
    localparam int BEATS     = NUM_ELEMS / LANES;
    localparam int BEAT_W    = LANES * WIDTH;

    typedef struct {
        logic              last;
        logic [BEAT_W-1:0] data;
    } beat_t;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       calc_done_flag;
    logic [NUM_ELEMS*WIDTH-1:0] in_c;
    logic                       relu_en;
    logic                       clear_err;
    logic [BEAT_W-1:0]          m_data;
    logic                       m_valid;
    logic                       m_ready;
    logic                       m_last;
    logic                       busy;
    logic                       drain_done;
    logic                       overrun_err;

    ndp_result_drain #(.WIDTH(WIDTH), .NUM_ELEMS(NUM_ELEMS), .LANES(LANES)) dut (
        .clk(clk), .reset(reset), .calc_done_flag(calc_done_flag), .in_c(in_c),
        .relu_en(relu_en), .clear_err(clear_err), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy), .drain_done(drain_done),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_fail   = 0;
    int               hs_cnt   = 0;
    beat_t            sb[$];
    logic [WIDTH-1:0] elems[NUM_ELEMS];
    logic             bp_stop;

    task automatic check(input string name, input logic [BEAT_W-1:0] got, input logic [BEAT_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic set_elems(input int kind);
        for (int i = 0; i < NUM_ELEMS; i++) begin
            case (kind)
                0:       elems[i] = 8'(i % 256);
                1:       elems[i] = (i % 2 == 0) ? 8'h85 : 8'h7F;
                2:       elems[i] = 8'(i % 256) ^ 8'h55;
                default: elems[i] = 8'((i * 3) % 256);
            endcase
            in_c[i*WIDTH +: WIDTH] = elems[i];
        end
    endtask

    task automatic push_job(input logic relu);
        beat_t            bt;
        logic [WIDTH-1:0] v;
        for (int b = 0; b < BEATS; b++) begin
            for (int l = 0; l < LANES; l++) begin
                v = elems[b*LANES + l];
                if (relu && v[WIDTH-1]) v = '0;
                bt.data[l*WIDTH +: WIDTH] = v;
            end
            bt.last = (b == BEATS - 1);
            sb.push_back(bt);
        end
    endtask

    // One-cycle flag pulse; capture at the next edge, valid/busy right after it.
    task automatic start_job(input logic relu);
        relu_en = relu;
        push_job(relu);
        @(posedge clk); #1 calc_done_flag = 1'b1;
        @(posedge clk); #1 calc_done_flag = 1'b0;
        @(negedge clk);
        check("latency_valid", BEAT_W'(m_valid), BEAT_W'(1));
        check("latency_busy", BEAT_W'(busy), BEAT_W'(1));
    endtask

    task automatic wait_drain();
        bit seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (drain_done) seen = 1;
        end
        check("drain_done_seen", BEAT_W'(seen), BEAT_W'(1));
        check("sb_drained", BEAT_W'(sb.size()), BEAT_W'(0));
        check("busy_after", BEAT_W'(busy), BEAT_W'(0));
        check("valid_after", BEAT_W'(m_valid), BEAT_W'(0));
        check("last_after", BEAT_W'(m_last), BEAT_W'(0));
        @(negedge clk);
        check("drain_done_pulse", BEAT_W'(drain_done), BEAT_W'(0));
    endtask

    task automatic wait_hs(input int target);
        bit ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (hs_cnt >= target) ok = 1;
        end
        check("wait_hs", BEAT_W'(ok), BEAT_W'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, BEAT_W'(m_valid), '0);
        check({tag, "_last"}, BEAT_W'(m_last), '0);
        check({tag, "_busy"}, BEAT_W'(busy), '0);
        check({tag, "_done"}, BEAT_W'(drain_done), '0);
        check({tag, "_err"}, BEAT_W'(overrun_err), '0);
        check({tag, "_data"}, m_data, '0);
    endtask

    // Monitor: compares each handshake against the scoreboard and checks stall hold.
    initial begin
        logic              prev_stall = 0;
        logic [BEAT_W-1:0] prev_data  = '0;
        logic              prev_last  = 0;
        beat_t             exp;
        forever begin
            @(negedge clk);
            if (reset) prev_stall = 0;
            else begin
                if (prev_stall) begin
                    check("stall_valid", BEAT_W'(m_valid), BEAT_W'(1));
                    check("stall_data", m_data, prev_data);
                    check("stall_last", BEAT_W'(m_last), BEAT_W'(prev_last));
                end
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_empty got=extra beat %0h exp=none t=%0t", m_data, $time);
                    end else begin
                        exp = sb.pop_front();
                        check("beat_data", m_data, exp.data);
                        check("beat_last", BEAT_W'(m_last), BEAT_W'(exp.last));
                    end
                    hs_cnt++;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1'b1; calc_done_flag = 1'b0; in_c = '0; relu_en = 1'b0;
        clear_err = 1'b0; m_ready = 1'b1; bp_stop = 1'b0;
        #3 check_all_zero("reset");
        @(posedge clk); #1 reset = 1'b0;

        // Single job, ramp data, full throughput.
        set_elems(0);
        start_job(1'b0);
        wait_drain();

        // ReLU on, then off; relu_en toggled mid-drain must not matter.
        set_elems(1);
        start_job(1'b1);
        relu_en = 1'b0;
        wait_drain();
        start_job(1'b0);
        relu_en = 1'b1;
        wait_drain();
        relu_en = 1'b0;

        // Backpressure with random low runs of 0..5 cycles.
        set_elems(3);
        base = hs_cnt;
        start_job(1'b0);
        fork
            begin
                for (int i = 0; i < 2000 && !bp_stop; i++) begin
                    @(posedge clk); #1 m_ready = 1'b0;
                    repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
                    m_ready = 1'b1;
                    repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                end
                m_ready = 1'b1;
            end
            begin
                wait_drain();
                bp_stop = 1'b1;
            end
        join
        m_ready = 1'b1;
        check("bp_hs_count", BEAT_W'(hs_cnt - base), BEAT_W'(BEATS));

        // Overrun: held-high flag gives one capture; a later rise mid-drain is dropped.
        set_elems(0);
        base = hs_cnt;
        push_job(1'b0);
        @(posedge clk); #1 calc_done_flag = 1'b1;
        wait_hs(base + 4);
        calc_done_flag = 1'b0;
        wait_hs(base + 10);
        set_elems(2);
        calc_done_flag = 1'b1;
        @(negedge clk);
        calc_done_flag = 1'b0;
        check("overrun_set", BEAT_W'(overrun_err), BEAT_W'(1));
        wait_drain();
        check("overrun_sticky", BEAT_W'(overrun_err), BEAT_W'(1));
        @(posedge clk); #1 clear_err = 1'b1;
        @(posedge clk); #1 clear_err = 1'b0;
        @(negedge clk);
        check("overrun_clear", BEAT_W'(overrun_err), BEAT_W'(0));

        // Back-to-back: new rise exactly on the beat-63 handshake edge.
        set_elems(0);
        start_job(1'b0);
        begin
            bit ok = 0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge clk);
                if (m_valid && m_last) ok = 1;
            end
            check("b2b_reach_last", BEAT_W'(ok), BEAT_W'(1));
        end
        set_elems(3);
        calc_done_flag = 1'b1;
        push_job(1'b0);
        @(negedge clk);
        calc_done_flag = 1'b0;
        check("b2b_valid", BEAT_W'(m_valid), BEAT_W'(1));
        check("b2b_busy", BEAT_W'(busy), BEAT_W'(1));
        check("b2b_done", BEAT_W'(drain_done), BEAT_W'(1));
        check("b2b_err", BEAT_W'(overrun_err), BEAT_W'(0));
        check("b2b_last", BEAT_W'(m_last), BEAT_W'(0));
        wait_drain();

        // Asynchronous reset mid-drain, flag high at release.
        set_elems(0);
        base = hs_cnt;
        start_job(1'b0);
        wait_hs(base + 30);
        #2 reset = 1'b1;
        #1 check_all_zero("mid_reset");
        sb.delete();
        set_elems(2);
        calc_done_flag = 1'b1;
        push_job(1'b0);
        @(posedge clk); #3 reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_rel_valid", BEAT_W'(m_valid), BEAT_W'(1));
        calc_done_flag = 1'b0;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
